// File: rtl/k6502_pkg.sv
// Shared constants and T-state encoding for the k6502 timing generator and decode logic.
package k6502_pkg;

  localparam int         T_MAX    = 7;
  localparam logic [7:0] OP_BRK   = 8'h00;
  localparam logic [7:0] RESET_OP = OP_BRK;

  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;
  localparam int T5_IDX = 4;
  localparam int T6_IDX = 5;
  localparam int T7_IDX = 6;

  typedef enum logic [T_MAX-1:0] {
    T1 = 7'b0000001,
    T2 = 7'b0000010,
    T3 = 7'b0000100,
    T4 = 7'b0001000,
    T5 = 7'b0010000,
    T6 = 7'b0100000,
    T7 = 7'b1000000
  } t_state_e;

endpackage

// File: rtl/k6502_opclass.sv
// Combinational classifier: flags opcodes that complete in two cycles (T1 fetch + T2 execute).
module k6502_opclass (
  input  logic [7:0] op_i,
  output logic       two_cycle_o
);

  // Implied/accumulator ops, immediates and single-byte flag ops; stack pushes/pulls
  // (08/28/48/68) and BRK (00) fall outside every term.
  assign two_cycle_o = (op_i[3:0] == 4'hA)
                     | (op_i[4:0] == 5'h09)
                     | ((op_i[3:0] == 4'h8) & (op_i[7] | op_i[4]))
                     | (op_i[7] & (op_i[4:2] == 3'b000) & ~op_i[0]);

endmodule

// File: rtl/k6502_timing_gen.sv
// IR latch and one-hot T1..T7 sequencer with RDY stalls and the reset sequence.
// Optional interrupt injection is built when K6502_INT_EN is defined.
module k6502_timing_gen
  import k6502_pkg::*;
(
  input  logic             ph0,
  input  logic             reset,
  input  logic [7:0]       pd_in,
  input  logic             rdy,
  input  logic             rw,
  input  logic             t_reset,
`ifdef K6502_INT_EN
  input  logic             nmi_pend,
  input  logic             irq_pend,
  output logic             int_seq,
`endif
  output logic [7:0]       ir,
  output logic [T_MAX-1:0] t_state,
  output logic             sync,
  output logic             last_cycle,
  output logic             rst_seq,
  output logic             t_overflow
);

  t_state_e   t_q, t_d;
  logic [7:0] ir_q, ir_d;
  logic       rst_seq_q, rst_seq_d;
  logic       t_ovf_q, t_ovf_d;
  logic       advance;
  logic       ir_two_cycle;
  logic       inject;

  k6502_opclass u_opclass (
    .op_i        (ir_q),
    .two_cycle_o (ir_two_cycle)
  );

  // Write cycles cannot be stretched, so RDY only stalls reads.
  assign advance    = rdy | ~rw;
  assign sync       = t_q[T1_IDX];
  assign last_cycle = (t_q[T2_IDX] & ir_two_cycle & ~rst_seq_q)
                    | (t_reset & ~t_q[T1_IDX])
                    | t_q[T_MAX-1];

`ifdef K6502_INT_EN
  logic int_seq_q, int_seq_d;

  // Both sources inject the same BRK-style sequence; int_seq does not record which one.
  always_comb begin
    int_seq_d = int_seq_q;
    if (advance && last_cycle) int_seq_d = nmi_pend | irq_pend;
  end

  always_ff @(posedge ph0) begin
    if (reset) int_seq_q <= 1'b0;
    else       int_seq_q <= int_seq_d;
  end

  assign inject  = int_seq_q;
  assign int_seq = int_seq_q;
`else
  assign inject = 1'b0;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    t_d       = t_q;
    ir_d      = ir_q;
    rst_seq_d = rst_seq_q;
    t_ovf_d   = 1'b0;
    if (advance) begin
      case (t_q)
        T1: begin
          t_d  = T2;
          ir_d = inject ? RESET_OP : pd_in;
        end
        T2, T3, T4, T5, T6: t_d = last_cycle ? T1 : t_state_e'(t_q << 1);
        T7: begin
          t_d     = T1;
          t_ovf_d = ~t_reset;
        end
        default: t_d = T1;
      endcase
      if (last_cycle) rst_seq_d = 1'b0;
    end
  end

  always_ff @(posedge ph0) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      t_q       <= T2;
      ir_q      <= RESET_OP;
      rst_seq_q <= 1'b1;
      t_ovf_q   <= 1'b0;
    end else begin
      t_q       <= t_d;
      ir_q      <= ir_d;
      rst_seq_q <= rst_seq_d;
      t_ovf_q   <= t_ovf_d;
    end
  end

  assign ir         = ir_q;
  assign t_state    = t_q;
  assign rst_seq    = rst_seq_q;
  assign t_overflow = t_ovf_q;

endmodule

// File: tb/tb_k6502_timing_gen.sv
// Directed bench for k6502_timing_gen; interrupt checks are added when K6502_INT_EN is defined.
module tb_k6502_timing_gen;

  localparam logic [6:0] S_T1 = 7'h01;
  localparam logic [6:0] S_T2 = 7'h02;
  localparam logic [6:0] S_T3 = 7'h04;
  localparam logic [6:0] S_T4 = 7'h08;
  localparam logic [6:0] S_T7 = 7'h40;

  logic       ph0 = 1'b0;
  logic       reset, rdy, rw, t_reset;
  logic [7:0] pd_in;
  logic [7:0] ir;
  logic [6:0] t_state;
  logic       sync, last_cycle, rst_seq, t_overflow;
`ifdef K6502_INT_EN
  logic       nmi_pend, irq_pend, int_seq;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 ph0 = ~ph0;

  k6502_timing_gen dut (
    .ph0        (ph0),
    .reset      (reset),
    .pd_in      (pd_in),
    .rdy        (rdy),
    .rw         (rw),
    .t_reset    (t_reset),
`ifdef K6502_INT_EN
    .nmi_pend   (nmi_pend),
    .irq_pend   (irq_pend),
    .int_seq    (int_seq),
`endif
    .ir         (ir),
    .t_state    (t_state),
    .sync       (sync),
    .last_cycle (last_cycle),
    .rst_seq    (rst_seq),
    .t_overflow (t_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ph0);
    @(negedge ph0);
  endtask

  task automatic expect_state(input string tag, input logic [6:0] t, input logic [7:0] op);
    check({tag, ".t_state"}, 32'(t_state), 32'(t));
    check({tag, ".ir"}, 32'(ir), 32'(op));
    check({tag, ".sync"}, 32'(sync), 32'(t == S_T1));
  endtask

  task automatic check_lc(input string tag, input logic exp);
    #1;
    check({tag, ".last_cycle"}, 32'(last_cycle), 32'(exp));
  endtask

  logic [7:0] two_ops [4] = '{8'hA9, 8'hEA, 8'h0A, 8'h18};

  initial begin
    reset = 1'b1; rdy = 1'b1; rw = 1'b1; t_reset = 1'b0; pd_in = 8'hEA;
`ifdef K6502_INT_EN
    nmi_pend = 1'b0; irq_pend = 1'b0;
`endif

    // Reset held three cycles, then the BRK-style sequence walks T2..T7.
    repeat (3) begin
      tick;
      expect_state("rst", S_T2, 8'h00);
      check("rst.rst_seq", 32'(rst_seq), 32'd1);
      check("rst.t_overflow", 32'(t_overflow), 32'd0);
    end
    reset = 1'b0;
    check_lc("rst.T2", 1'b0);
    for (int k = 3; k <= 7; k++) begin
      tick;
      expect_state($sformatf("rstwalk.T%0d", k), 7'(1 << (k - 1)), 8'h00);
      check($sformatf("rstwalk.T%0d.rst_seq", k), 32'(rst_seq), 32'd1);
    end
    t_reset = 1'b1;
    check_lc("rst.T7", 1'b1);
    tick;
    t_reset = 1'b0;
    expect_state("rst.end", S_T1, 8'h00);
    check("rst.end.rst_seq", 32'(rst_seq), 32'd0);
    check("rst.end.t_overflow", 32'(t_overflow), 32'd0);

    // Two-cycle opcodes: T1 -> T2 (last) -> T1.
    foreach (two_ops[i]) begin
      pd_in = two_ops[i];
      tick;
      expect_state($sformatf("two.%0h.T2", two_ops[i]), S_T2, two_ops[i]);
      check_lc($sformatf("two.%0h", two_ops[i]), 1'b1);
      tick;
      expect_state($sformatf("two.%0h.T1", two_ops[i]), S_T1, two_ops[i]);
      check($sformatf("two.%0h.t_overflow", two_ops[i]), 32'(t_overflow), 32'd0);
    end

    // PHA: not two-cycle, ends on t_reset in T3.
    pd_in = 8'h48;
    tick;
    expect_state("pha.T2", S_T2, 8'h48);
    check_lc("pha.T2", 1'b0);
    tick;
    expect_state("pha.T3", S_T3, 8'h48);
    t_reset = 1'b1;
    check_lc("pha.T3", 1'b1);
    tick;
    t_reset = 1'b0;
    expect_state("pha.T1", S_T1, 8'h48);

    // t_reset during T1 is ignored.
    pd_in = 8'hAD;
    t_reset = 1'b1;
    check_lc("t1_treset", 1'b0);
    tick;
    t_reset = 1'b0;
    expect_state("t1_treset.T2", S_T2, 8'hAD);

    // RDY stall on read cycles; writes proceed regardless.
    rdy = 1'b0;
    pd_in = 8'hEA;
    repeat (4) begin
      tick;
      expect_state("stall.T2", S_T2, 8'hAD);
    end
    rw = 1'b0;
    tick;
    expect_state("stall.write", S_T3, 8'hAD);
    rdy = 1'b1; rw = 1'b1; t_reset = 1'b1;
    tick;
    t_reset = 1'b0;
    expect_state("stall.end", S_T1, 8'hAD);
    rdy = 1'b0;
    pd_in = 8'h6C;
    tick;
    expect_state("stall.T1", S_T1, 8'hAD);
    rdy = 1'b1;
    tick;
    expect_state("jmpi.T2", S_T2, 8'h6C);

    // JMP (ind) without t_reset overruns to T7 and is forced back to T1.
    for (int k = 3; k <= 7; k++) begin
      tick;
      expect_state($sformatf("ovf.T%0d", k), 7'(1 << (k - 1)), 8'h6C);
      check($sformatf("ovf.T%0d.t_overflow", k), 32'(t_overflow), 32'd0);
    end
    check_lc("ovf.T7", 1'b1);
    pd_in = 8'hEA;
    tick;
    expect_state("ovf.T1", S_T1, 8'h6C);
    check("ovf.pulse", 32'(t_overflow), 32'd1);
    tick;
    expect_state("ovf.after", S_T2, 8'hEA);
    check("ovf.after.t_overflow", 32'(t_overflow), 32'd0);
    tick;
    expect_state("ovf.done", S_T1, 8'hEA);

    // Reset mid-instruction dominates a stalled RDY.
    pd_in = 8'h6D;
    tick;
    tick;
    tick;
    expect_state("mid.T4", S_T4, 8'h6D);
    reset = 1'b1; rdy = 1'b0;
    tick;
    reset = 1'b0; rdy = 1'b1;
    expect_state("mid.rst", S_T2, 8'h00);
    check("mid.rst_seq", 32'(rst_seq), 32'd1);
    check_lc("mid.rst", 1'b0);
    t_reset = 1'b1;
    tick;
    t_reset = 1'b0;
    expect_state("mid.end", S_T1, 8'h00);
    check("mid.end.rst_seq", 32'(rst_seq), 32'd0);

`ifdef K6502_INT_EN
    // IRQ at the last cycle of LDA # injects BRK in place of the fetched opcode.
    pd_in = 8'hA9;
    tick;
    expect_state("irq.lda", S_T2, 8'hA9);
    check("irq.idle.int_seq", 32'(int_seq), 32'd0);
    irq_pend = 1'b1;
    pd_in = 8'hEA;
    tick;
    irq_pend = 1'b0;
    expect_state("irq.T1", S_T1, 8'hA9);
    check("irq.T1.int_seq", 32'(int_seq), 32'd1);
    tick;
    expect_state("irq.T2", S_T2, 8'h00);
    check("irq.T2.int_seq", 32'(int_seq), 32'd1);
    check_lc("irq.T2", 1'b0);
    t_reset = 1'b1;
    tick;
    t_reset = 1'b0;
    expect_state("irq.end", S_T1, 8'h00);
    check("irq.end.int_seq", 32'(int_seq), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
